// File: rtl/mdc_commutator.sv
// Two-path MDC commutator: delays path A by DEPTH, swaps paths every DEPTH accepts, delays path 1 by DEPTH.
// Optional synchronous clear input 'clr' when MDC_COMM_SYNC_CLR_EN is defined.
module mdc_commutator #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MDC_COMM_SYNC_CLR_EN
    input  logic             clr,
`endif
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_re,
    input  logic [WIDTH-1:0] a_im,
    input  logic [WIDTH-1:0] b_re,
    input  logic [WIDTH-1:0] b_im,
    output logic             out_valid,
    output logic             out_sop,
    output logic [WIDTH-1:0] y0_re,
    output logic [WIDTH-1:0] y0_im,
    output logic [WIDTH-1:0] y1_re,
    output logic [WIDTH-1:0] y1_im
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = 2 * WIDTH;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          fill_q, fill_d;
    logic [SW-1:0] delayA_q  [DEPTH];
    logic [SW-1:0] delayP1_q [DEPTH];
    logic [SW-1:0] y0_q, y1_q;
    logic          outValid_q, outSop_q;

    logic          syncClr;
    logic [AW-1:0] addr;
    logic          swap;
    logic [SW-1:0] sampleB;
    logic [SW-1:0] upperDelayed;
    logic [SW-1:0] path1Delayed;
    logic [SW-1:0] p0, p1;

`ifdef MDC_COMM_SYNC_CLR_EN
    assign syncClr = clr;
`else
    assign syncClr = 1'b0;
`endif

    // Both delay lines are circular buffers sharing the low counter bits: the
    // cell at addr holds the sample accepted exactly DEPTH accepts ago.
    assign addr         = cnt_q[AW-1:0];
    assign swap         = cnt_q[AW];
    assign sampleB      = {b_re, b_im};
    assign upperDelayed = delayA_q[addr];
    assign path1Delayed = delayP1_q[addr];

    always_comb begin
        p0 = upperDelayed;
        p1 = sampleB;
        if (swap) begin
            p0 = sampleB;
            p1 = upperDelayed;
        end
    end

    // Counter width is exactly log2(2*DEPTH), so it wraps with no bubble.
    always_comb begin
        cnt_d  = cnt_q;
        fill_d = fill_q;
        if (in_valid) begin
            cnt_d  = cnt_q + CW'(1);
            fill_d = fill_q | (cnt_q == CW'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            fill_q <= 1'b0;
        end else if (syncClr) begin
            cnt_q  <= '0;
            fill_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                delayA_q[i]  <= '0;
                delayP1_q[i] <= '0;
            end
        end else if (syncClr) begin
            for (int i = 0; i < DEPTH; i++) begin
                delayA_q[i]  <= '0;
                delayP1_q[i] <= '0;
            end
        end else if (in_valid) begin
            delayA_q[addr]  <= {a_re, a_im};
            delayP1_q[addr] <= p1;
        end
    end

    // Data registers hold through stalls; only the valid/sop flags drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q       <= '0;
            y1_q       <= '0;
            outValid_q <= 1'b0;
            outSop_q   <= 1'b0;
        end else if (syncClr) begin
            y0_q       <= '0;
            y1_q       <= '0;
            outValid_q <= 1'b0;
            outSop_q   <= 1'b0;
        end else begin
            outValid_q <= in_valid & fill_q;
            outSop_q   <= in_valid & fill_q & (cnt_q == CW'(DEPTH));
            if (in_valid) begin
                y0_q <= p0;
                y1_q <= path1Delayed;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_sop   = outSop_q;
    assign y0_re     = y0_q[SW-1:WIDTH];
    assign y0_im     = y0_q[WIDTH-1:0];
    assign y1_re     = y1_q[SW-1:WIDTH];
    assign y1_im     = y1_q[WIDTH-1:0];

endmodule

// File: tb/tb_mdc_commutator.sv
// Scoreboard bench for mdc_commutator: a DEPTH=2 and a DEPTH=16 instance checked against
// a history-based model of the switch/delay equations.
module tb_mdc_commutator;

    localparam int W  = 9;
    localparam int D0 = 2;
    localparam int D1 = 16;
    localparam int N  = 16384;

    typedef struct packed {
        logic         valid;
        logic         sop;
        logic [2*W-1:0] y0;
        logic [2*W-1:0] y1;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] inValid;
    logic [1:0] clrT;
    logic [W-1:0] aRe[2], aIm[2], bRe[2], bIm[2];
    logic [1:0] outValid, outSop;
    logic [W-1:0] y0Re[2], y0Im[2], y1Re[2], y1Im[2];

    logic [2*W-1:0] histA[2][N];
    logic [2*W-1:0] histB[2][N];
    int kCnt[2];
    pair_t expQ0[$];
    pair_t expQ1[$];
    pair_t lastPair[2];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mdc_commutator #(.DEPTH(D0), .WIDTH(W)) dut0 (
        .clk(clk), .rst_n(rst_n),
`ifdef MDC_COMM_SYNC_CLR_EN
        .clr(clrT[0]),
`endif
        .in_valid(inValid[0]),
        .a_re(aRe[0]), .a_im(aIm[0]), .b_re(bRe[0]), .b_im(bIm[0]),
        .out_valid(outValid[0]), .out_sop(outSop[0]),
        .y0_re(y0Re[0]), .y0_im(y0Im[0]), .y1_re(y1Re[0]), .y1_im(y1Im[0])
    );

    mdc_commutator #(.DEPTH(D1), .WIDTH(W)) dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef MDC_COMM_SYNC_CLR_EN
        .clr(clrT[1]),
`endif
        .in_valid(inValid[1]),
        .a_re(aRe[1]), .a_im(aIm[1]), .b_re(bRe[1]), .b_im(bIm[1]),
        .out_valid(outValid[1]), .out_sop(outSop[1]),
        .y0_re(y0Re[1]), .y0_im(y0Im[1]), .y1_re(y1Re[1]), .y1_im(y1Im[1])
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: outputs computed straight from the stored input history.
    function automatic int depthOf(input int u);
        return (u == 0) ? D0 : D1;
    endfunction

    function automatic logic [2*W-1:0] upperDelayedOf(input int u, input int k);
        int d = depthOf(u);
        return (k >= d) ? histA[u][k-d] : '0;
    endfunction

    function automatic logic swapOf(input int u, input int k);
        int d = depthOf(u);
        return (k % (2 * d)) >= d;
    endfunction

    function automatic logic [2*W-1:0] path0Of(input int u, input int k);
        return swapOf(u, k) ? histB[u][k] : upperDelayedOf(u, k);
    endfunction

    function automatic logic [2*W-1:0] path1Of(input int u, input int k);
        return swapOf(u, k) ? upperDelayedOf(u, k) : histB[u][k];
    endfunction

    function automatic pair_t refPair(input int u, input int k);
        pair_t p;
        int d = depthOf(u);
        p.valid = (k >= d);
        p.sop   = (k >= d) && (((k - d) % (2 * d)) == 0);
        p.y0    = path0Of(u, k);
        p.y1    = (k >= d) ? path1Of(u, k - d) : '0;
        return p;
    endfunction

    task automatic modelClear(input int u);
        kCnt[u] = 0;
        lastPair[u] = '0;
        if (u == 0) expQ0.delete();
        else expQ1.delete();
    endtask

    task automatic modelAccept(input int u);
        int k = kCnt[u];
        histA[u][k] = {aRe[u], aIm[u]};
        histB[u][k] = {bRe[u], bIm[u]};
        if (u == 0) expQ0.push_back(refPair(u, k));
        else expQ1.push_back(refPair(u, k));
        kCnt[u] = k + 1;
    endtask

    task automatic applyStimulus(input int u, input logic valid, input logic [W-1:0] ar,
                                 input logic [W-1:0] ai, input logic [W-1:0] br, input logic [W-1:0] bi);
        @(negedge clk);
        inValid = '0;
        clrT = '0;
        inValid[u] = valid;
        aRe[u] = ar; aIm[u] = ai; bRe[u] = br; bIm[u] = bi;
        if (valid) modelAccept(u);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        inValid = '0;
        clrT = '0;
        modelClear(0);
        modelClear(1);
        #1;
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("u%0d reset valid", u), 64'(outValid[u]), 64'd0);
            checkOutput($sformatf("u%0d reset sop", u), 64'(outSop[u]), 64'd0);
            checkOutput($sformatf("u%0d reset y", u),
                        {28'd0, y0Re[u], y0Im[u], y1Re[u], y1Im[u]}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic compareAccepted(input int u, input pair_t it);
        checkOutput($sformatf("u%0d out_valid k=%0d", u, kCnt[u]), 64'(outValid[u]), 64'(it.valid));
        if (it.valid) begin
            checkOutput($sformatf("u%0d out_sop", u), 64'(outSop[u]), 64'(it.sop));
            checkOutput($sformatf("u%0d y0", u), 64'({y0Re[u], y0Im[u]}), 64'(it.y0));
            checkOutput($sformatf("u%0d y1", u), 64'({y1Re[u], y1Im[u]}), 64'(it.y1));
        end
    endtask

    task automatic compareIdle(input int u);
        checkOutput($sformatf("u%0d idle out_valid", u), 64'(outValid[u]), 64'd0);
        checkOutput($sformatf("u%0d idle y0 held", u), 64'({y0Re[u], y0Im[u]}), 64'(lastPair[u].y0));
        checkOutput($sformatf("u%0d idle y1 held", u), 64'({y1Re[u], y1Im[u]}), 64'(lastPair[u].y1));
    endtask

    // Monitors: an edge that accepted a sample must present the next queued pair.
    always @(posedge clk) begin : monitor0
        logic acc;
        pair_t it;
        acc = inValid[0] && rst_n && !clrT[0];
        #1;
        if (acc) begin
            if (expQ0.size() == 0) checkOutput("u0 unexpected accept", 64'd1, 64'd0);
            else begin
                it = expQ0.pop_front();
                compareAccepted(0, it);
                lastPair[0] = it;
            end
        end else compareIdle(0);
    end

    always @(posedge clk) begin : monitor1
        logic acc;
        pair_t it;
        acc = inValid[1] && rst_n && !clrT[1];
        #1;
        if (acc) begin
            if (expQ1.size() == 0) checkOutput("u1 unexpected accept", 64'd1, 64'd0);
            else begin
                it = expQ1.pop_front();
                compareAccepted(1, it);
                lastPair[1] = it;
            end
        end else compareIdle(1);
    end

    task automatic directedSample(input int u, input int k);
        applyStimulus(u, 1'b1, W'(9'h10 + k), W'(9'h30 + k), W'(9'h20 + k), W'(9'h40 + k));
    endtask

    initial begin
        int k;
        int c;
        rst_n = 1'b0;
        inValid = '0;
        clrT = '0;
        for (int u = 0; u < 2; u++) begin
            aRe[u] = '0; aIm[u] = '0; bRe[u] = '0; bIm[u] = '0;
            kCnt[u] = 0;
            lastPair[u] = '0;
        end
        #12;
        rst_n = 1'b1;
        applyReset();

        $display("[TB] DEPTH=2 continuous stream");
        for (int i = 0; i < 8; i++) directedSample(0, i);

        $display("[TB] DEPTH=2 stream with a gap every third cycle");
        applyReset();
        k = 0;
        c = 0;
        while (k < 8) begin
            if (c % 3 == 2) applyStimulus(0, 1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            else begin
                directedSample(0, k);
                k++;
            end
            c++;
        end

        $display("[TB] reset mid-stream and refill");
        applyReset();
        for (int i = 0; i < 6; i++) directedSample(0, i);
        applyReset();
        for (int i = 0; i < 6; i++) directedSample(0, i);

        $display("[TB] DEPTH=16 extreme values");
        for (int i = 0; i < 40; i++) applyStimulus(1, 1'b1, W'(255), W'(9'h100), W'(255), W'(9'h100));

`ifdef MDC_COMM_SYNC_CLR_EN
        $display("[TB] synchronous clear at k=4");
        applyReset();
        for (int i = 0; i < 4; i++) directedSample(0, i);
        @(negedge clk);
        inValid = '0;
        clrT = '0;
        inValid[0] = 1'b1;
        clrT[0] = 1'b1;
        aRe[0] = W'(9'h14); aIm[0] = W'(9'h34); bRe[0] = W'(9'h24); bIm[0] = W'(9'h44);
        modelClear(0);
        for (int i = 0; i < 6; i++) directedSample(0, i);
`endif

        $display("[TB] random stream on DEPTH=2");
        k = 0;
        while (k < 1500) begin
            logic v;
            v = ($urandom_range(3) != 0);
            applyStimulus(0, v, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            if (v) k++;
        end

        $display("[TB] random stream on DEPTH=16");
        k = 0;
        while (k < 10000) begin
            logic v;
            v = ($urandom_range(3) != 0);
            applyStimulus(1, v, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
            if (v) k++;
        end

        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, '0, '0, '0, '0);
        checkOutput("u0 scoreboard drained", 64'(expQ0.size()), 64'd0);
        checkOutput("u1 scoreboard drained", 64'(expQ1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
